sram_ctrl: RTL and testbench

Synchronous initiator for the 128k x 8 asynchronous SRAM (CY62128E-style, active when CE1=0 and CE2=1). It accepts single-byte read/write commands from the datapath over a valid/ready handshake. It sequences the chip's CE1/CE2/WE/OE strobes, address and tri-state data bus with fixed setup/strobe/hold phases, and returns read data with a one-cycle valid pulse. It sits between the CPU-side bus logic and the SRAM pins, and replaces the combinational strobe derivation with a clocked, contention-free sequence.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_wait_counter.sv | 35 +++
 rtl/sram_ctrl.sv | 151 +++++++++++++++
 tb/tb_sram_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, widths and idle pin levels for the SRAM controller.
package sram_ctrl_pkg;

  localparam int DATA_W      = 8;
  localparam int CHIP_ADDR_W = 17;
  localparam int PTR_W       = 8;
  localparam int WAIT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Pin levels that leave the chip deselected and quiet.
  localparam logic CE1_OFF = 1'b1;
  localparam logic CE2_OFF = 1'b0;
  localparam logic WE_OFF  = 1'b1;
  localparam logic OE_OFF  = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Strobe-length down-counter: loaded with the strobe length minus one, done at zero.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter logic [WAIT_W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Clocked SETUP/STROBE/HOLD sequencer for a 128k x 8 async SRAM, one byte per command.
// Optional sequential address pointer enabled by defining SRAM_CTRL_AUTOINC_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  input  logic                   cmd_seq,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [CHIP_ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0]      sram_data,
  output logic                   sram_ce1,
  output logic                   sram_ce2,
  output logic                   sram_we,
  output logic                   sram_oe
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]   acc_addr;
  logic                accept;
  logic                strobe_done;
  logic                drive_en;

  // Ready drops combinationally with rst so nothing is accepted during reset.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

`ifdef SRAM_CTRL_AUTOINC_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign acc_addr = cmd_seq ? ADDR_W'(ptr_q) : cmd_addr;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = PTR_W'(acc_addr) + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_seq;
  assign unused_seq = cmd_seq;
  assign acc_addr   = cmd_addr;
`endif

  sram_wait_counter #(
    .LOAD_VAL(WAIT_W'(STROBE_CYCLES - 1))
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .load_i(state_q == SETUP),
    .en_i  (state_q == STROBE),
    .done_o(strobe_done)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          we_d    = cmd_we;
          addr_d  = acc_addr;
          wdata_d = cmd_wdata;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        if (strobe_done) begin
          state_d = HOLD;
          // Sample on the edge that closes the last OE-low cycle.
          if (!we_q) begin
            rd_data_d = sram_data;
          end
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Strobes decode from registered state only, so WE and OE can never overlap.
  always_comb begin
    sram_ce1 = CE1_OFF;
    sram_ce2 = CE2_OFF;
    sram_we  = WE_OFF;
    sram_oe  = OE_OFF;
    drive_en = 1'b0;
    rd_valid = 1'b0;
    if (state_q != IDLE) begin
      sram_ce1 = ~CE1_OFF;
      sram_ce2 = ~CE2_OFF;
      drive_en = we_q;
    end
    if (state_q == STROBE) begin
      if (we_q) begin
        sram_we = ~WE_OFF;
      end else begin
        sram_oe = ~OE_OFF;
      end
    end
    if (state_q == HOLD) begin
      rd_valid = !we_q;
    end
  end

  assign sram_addr = CHIP_ADDR_W'(addr_q);
  assign sram_data = drive_en ? wdata_q : {DATA_W{1'bz}};
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM chip, reference memory/pointer model, directed and random commands.
module tb_sram_ctrl;

  localparam int PER = 10;
  localparam int S1  = 1;
  localparam int S3  = 3;

  logic clk = 1'b0;
  always #(PER/2) clk = ~clk;

  logic        rst;
  logic        cmd_valid, cmd_we, cmd_seq;
  logic [7:0]  cmd_addr, cmd_wdata;
  logic        cmd_ready, rd_valid;
  logic [7:0]  rd_data;
  logic [16:0] sram_addr;
  wire  [7:0]  sram_data;
  logic        sram_ce1, sram_ce2, sram_we, sram_oe;

  logic        c3_valid, c3_we;
  logic [7:0]  c3_addr, c3_wdata;
  logic        r3_ready, r3_valid;
  logic [7:0]  r3_data;
  logic [16:0] a3;
  wire  [7:0]  bus3;
  logic        ce1_3, ce2_3, we3, oe3;

  sram_ctrl #(.ADDR_W(8), .STROBE_CYCLES(S1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_seq(cmd_seq), .rd_data(rd_data),
    .rd_valid(rd_valid), .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce1(sram_ce1),
    .sram_ce2(sram_ce2), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  sram_ctrl #(.ADDR_W(8), .STROBE_CYCLES(S3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(r3_ready), .cmd_we(c3_we),
    .cmd_addr(c3_addr), .cmd_wdata(c3_wdata), .cmd_seq(1'b0), .rd_data(r3_data),
    .rd_valid(r3_valid), .sram_addr(a3), .sram_data(bus3), .sram_ce1(ce1_3),
    .sram_ce2(ce2_3), .sram_we(we3), .sram_oe(oe3)
  );

  // Behavioural chip: drives on selected OE-low read, latches on the rising edge of WE.
  logic [7:0] chip_mem [256];
  logic [7:0] ref_mem  [256];
  logic [7:0] ptr_m;
  logic       probe_en;
  logic [7:0] probe_val;
  wire        chip_rd = !sram_ce1 && sram_ce2 && !sram_oe && sram_we;

  assign sram_data = chip_rd ? chip_mem[sram_addr[7:0]] : (probe_en ? probe_val : 8'bz);
  assign bus3      = (!ce1_3 && ce2_3 && !oe3) ? 8'h96 : 8'bz;

  always @(posedge sram_we) begin
    if (!sram_ce1 && sram_ce2) chip_mem[sram_addr[7:0]] <= sram_data;
  end

  int overlap = 0;
  always @(negedge clk) begin
    if ((!sram_we && !sram_oe) || (!we3 && !oe3)) overlap <= overlap + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Bus must be undriven by the DUT: an opposing probe has to read back exactly.
  task automatic chk_z(input string nm);
    probe_en = 1'b1; probe_val = 8'h00;
    #1 chk({nm, "_z00"}, {24'h0, sram_data}, 32'h00);
    probe_val = 8'hFF;
    #1 chk({nm, "_zFF"}, {24'h0, sram_data}, 32'hFF);
    probe_en = 1'b0;
  endtask

  task automatic do_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic seq, output logic [7:0] rd, output int lat, output int vcnt,
                        output int welow, output int oelow, output logic [16:0] addr_seen);
    int t;
    t = 0; rd = '0; lat = -1; vcnt = 0; welow = 0; oelow = 0; addr_seen = '1;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_seq = seq;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!sram_we) begin welow++; addr_seen = sram_addr; end
      if (!sram_oe) begin oelow++; addr_seen = sram_addr; end
      if (rd_valid) begin
        vcnt++;
        if (lat < 0) begin lat = i; rd = rd_data; end
      end
      if (cmd_ready) break;
    end
  endtask

  task automatic run_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                         input logic seq, input string nm, output logic [7:0] rd);
    logic [7:0]  eff;
    logic [16:0] aseen;
    int lat, vcnt, welow, oelow;
`ifdef SRAM_CTRL_AUTOINC_EN
    eff   = seq ? ptr_m : addr;
    ptr_m = eff + 8'd1;
`else
    eff   = addr;
`endif
    do_cmd(we, addr, wd, seq, rd, lat, vcnt, welow, oelow, aseen);
    chk({nm, "_addr"}, {15'h0, aseen}, {24'h0, eff});
    if (we) begin
      ref_mem[eff] = wd;
      chk({nm, "_we_low"}, welow, S1);
      chk({nm, "_no_rdvld"}, vcnt, 0);
    end else begin
      chk({nm, "_rdata"}, {24'h0, rd}, {24'h0, ref_mem[eff]});
      chk({nm, "_rd_lat"}, lat, 1 + S1 + 1);
      chk({nm, "_rdvld_len"}, vcnt, 1);
      chk({nm, "_oe_low"}, oelow, S1);
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
  } vec_t;

  initial begin : watchdog
    #(PER * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [7];
    logic [7:0]  rd;
    logic [7:0]  exp_a;
    time         tacc [4];
    int          t, rv, lat, oec, wec;

    vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 8'h00, 8'hA5, 8'h00};
    vecs[3] = '{1'b1, 8'hFF, 8'h3C, 8'h00};
    vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[6] = '{1'b0, 8'h11, 8'h00, 8'h4D};

    for (int i = 0; i < 256; i++) begin
      chip_mem[i] = 8'(i) ^ 8'h5C;
      ref_mem[i]  = 8'(i) ^ 8'h5C;
    end
    ptr_m = 8'h00; probe_en = 1'b0; probe_val = 8'h00;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_seq = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    c3_valid = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;

    // Reset held for two edges.
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_ready_low", cmd_ready, 0);
    chk("rst_ce1", sram_ce1, 1);
    chk("rst_ce2", sram_ce2, 0);
    chk("rst_we", sram_we, 1);
    chk("rst_oe", sram_oe, 1);
    chk("rst_addr", {15'h0, sram_addr}, 0);
    chk("rst_rd_data", {24'h0, rd_data}, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk_z("rst");
    rst = 1'b0;
    #1 chk("rst_release_ready", cmd_ready, 1);
    chk("rst_release_ready3", r3_ready, 1);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].we, vecs[i].addr, vecs[i].wd, 1'b0, $sformatf("vec%0d", i), rd);
      if (!vecs[i].we) chk($sformatf("vec%0d_table_rd", i), {24'h0, rd}, {24'h0, vecs[i].exp_rd});
    end
    chk_z("idle");

    // Pointer wrap: write 0xFF, then a sequential read.
    run_cmd(1'b1, 8'hFF, 8'h77, 1'b0, "seq_wr", rd);
    run_cmd(1'b0, 8'h05, 8'h00, 1'b1, "seq_rd", rd);
`ifdef SRAM_CTRL_AUTOINC_EN
    exp_a = 8'h00;
`else
    exp_a = 8'h05;
`endif
    chk("seq_rd_value", {24'h0, rd}, {24'h0, ref_mem[exp_a]});

    // Back-to-back writes with cmd_valid held high throughout.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_seq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmd_addr = 8'h20 + 8'(k); cmd_wdata = 8'(k);
      t = 0;
      while (!cmd_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("b2b_ready%0d", k), cmd_ready, 1);
      @(posedge clk);
      tacc[k] = $time;
      ref_mem[8'h20 + 8'(k)] = 8'(k);
      ptr_m = 8'h21 + 8'(k);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("b2b_gap%0d", k), 32'((tacc[k] - tacc[k-1]) / PER), 3 + S1);
    end
    for (int k = 0; k < 4; k++) begin
      run_cmd(1'b0, 8'h20 + 8'(k), 8'h00, 1'b0, $sformatf("b2b_rd%0d", k), rd);
    end

    // STROBE_CYCLES=3 instance: read then write.
    c3_valid = 1'b1; c3_we = 1'b0; c3_addr = 8'h07;
    @(posedge clk);
    #1 c3_valid = 1'b0;
    lat = -1; oec = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!oe3) begin
        oec++;
        chk("s3_strobe_addr", {15'h0, a3}, 32'h07);
      end
      if (r3_valid && lat < 0) lat = i;
      if (r3_ready) break;
    end
    chk("s3_oe_low", oec, S3);
    chk("s3_rd_lat", lat, 1 + S3 + 1);
    chk("s3_rd_data", {24'h0, r3_data}, 32'h96);
    c3_valid = 1'b1; c3_we = 1'b1; c3_addr = 8'h08; c3_wdata = 8'h11;
    @(posedge clk);
    #1 c3_valid = 1'b0;
    wec = 0; rv = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!we3) wec++;
      if (r3_valid) rv++;
      if (r3_ready) break;
    end
    chk("s3_we_low", wec, S3);
    chk("s3_wr_no_rdvld", rv, 0);

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
              ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n), rd);
    end

    // Reset in the middle of a write strobe.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h30; cmd_wdata = 8'hEE; cmd_seq = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("midwr_we_active", sram_we, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midwr_we", sram_we, 1);
    chk("midwr_ce1", sram_ce1, 1);
    chk("midwr_ce2", sram_ce2, 0);
    chk("midwr_oe", sram_oe, 1);
    chk("midwr_ready", cmd_ready, 0);
    chk("midwr_rdvld", rd_valid, 0);
    chk("midwr_rd_data", {24'h0, rd_data}, 0);
    chk_z("midwr");
    rst = 1'b0;
    #1 chk("midwr_ready_after", cmd_ready, 1);
    @(negedge clk);

    // Reset in the middle of a read strobe: no rd_valid may follow.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h12;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("midrd_oe_active", sram_oe, 0);
    rst = 1'b1;
    @(negedge clk);
    rv = rd_valid ? 1 : 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_valid) rv++;
    end
    chk("midrd_no_rdvld", rv, 0);
    chk("midrd_rd_data", {24'h0, rd_data}, 0);
    chk("midrd_ready", cmd_ready, 1);

    chk("we_oe_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
